// File: rtl/serial_magnitude_comparator_pkg.sv
// serial_magnitude_comparator_pkg: state encoding and sizing helper shared by the serial comparator files.
package serial_magnitude_comparator_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_magnitude_comparator_slice.sv
// bit_compare_slice: one stage of an MSB-first equal/greater cascade.
module bit_compare_slice (
   input  logic a1,
   input  logic b1,
   input  logic e0,
   input  logic g0,
   output logic e1,
   output logic g1
);

   always_comb begin
      e1 = e0 & ~(a1 ^ b1);
      g1 = g0 | (e0 & a1 & ~b1);
   end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: unsigned compare of a and b, one bit per clock MSB-first through a single slice.
module serial_magnitude_comparator
   import serial_magnitude_comparator_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   localparam int CW = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             e_q, e_d, g_q, g_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
   logic             e1, g1, accept, shift, last;

   bit_compare_slice u_slice (
      .a1(sa_q[WIDTH-1]),
      .b1(sb_q[WIDTH-1]),
      .e0(e_q),
      .g0(g_q),
      .e1(e1),
      .g1(g1)
   );

   // The illegal encoding 2'd3 falls through to IDLE.
   always_comb begin
      accept  = start && (state_q == IDLE || state_q == DONE);
      shift   = state_q == SHIFT;
      last    = shift && cnt_q == '0;
      state_d = accept ? SHIFT : shift ? (last ? DONE : SHIFT) : IDLE;
      sa_d    = accept ? a : shift ? sa_q << 1 : sa_q;
      sb_d    = accept ? b : shift ? sb_q << 1 : sb_q;
      e_d     = accept ? 1'b1 : shift ? e1 : e_q;
      g_d     = accept ? 1'b0 : shift ? g1 : g_q;
      cnt_d   = accept ? CW'(WIDTH - 1) : (shift && !last) ? cnt_q - CW'(1) : cnt_q;
      busy_d  = state_d == SHIFT;
      done_d  = last;
      eq_d    = last ? e1 : eq_q;
      gt_d    = last ? g1 : gt_q;
      lt_d    = last ? (~e1 & ~g1) : lt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         cnt_q   <= '0;
         e_q     <= 1'b1;
         g_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         cnt_q   <= cnt_d;
         e_q     <= e_d;
         g_q     <= g_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
         lt_q    <= lt_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign eq   = eq_q;
   assign gt   = gt_q;
   assign lt   = lt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator: directed checks of an 8-bit and a 1-bit serial comparator.
module tb_serial_magnitude_comparator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start8 = 1'b0, start1 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       a1 = 1'b0, b1 = 1'b0;
   logic       busy8, done8, eq8, gt8, lt8;
   logic       busy1, done1, eq1, gt1, lt1;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [2:0] prev8 = 3'b000;

   always #5 clk = ~clk;

   serial_magnitude_comparator #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .eq(eq8), .gt(gt8), .lt(lt8)
   );

   serial_magnitude_comparator #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1)
   );

   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed {busy,done,eq,gt,lt}=%b expected %b", tag, obs, exp);
      end
   endtask

   // Called at a negedge; start is accepted at the following rising edge (edge 0).
   // Checks cycles 1..9 and returns at the negedge of the done cycle.
   task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic [2:0] res, input int inj);
      start8 = 1'b1; a8 = av; b8 = bv;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         start8 = 1'b0;
         chk($sformatf("%s busy c%0d", tag, i), {busy8, done8, eq8, gt8, lt8}, {2'b10, prev8});
         if (i == inj) begin
            start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
         end
      end
      @(negedge clk);
      start8 = 1'b0;
      chk($sformatf("%s done", tag), {busy8, done8, eq8, gt8, lt8}, {2'b01, res});
      prev8 = res;
   endtask

   initial begin
      #1;
      chk("reset w8", {busy8, done8, eq8, gt8, lt8}, 5'b00000);
      chk("reset w1", {busy1, done1, eq1, gt1, lt1}, 5'b00000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle w8", {busy8, done8, eq8, gt8, lt8}, 5'b00000);

      run8("eq 5A/5A", 8'h5A, 8'h5A, 3'b100, 0);
      @(negedge clk);
      chk("idle after eq", {busy8, done8, eq8, gt8, lt8}, 5'b00100);

      run8("gt 80/7F", 8'h80, 8'h7F, 3'b010, 0);
      @(negedge clk);

      run8("lt 00/FF", 8'h00, 8'hFF, 3'b001, 0);
      run8("b2b gt FF/FE", 8'hFF, 8'hFE, 3'b010, 0);
      @(negedge clk);
      chk("idle after b2b", {busy8, done8, eq8, gt8, lt8}, 5'b00010);

      run8("ignore mid start", 8'h03, 8'h03, 3'b100, 4);
      @(negedge clk);
      chk("no requeue", {busy8, done8, eq8, gt8, lt8}, 5'b00100);

      // Async reset in cycle 4 of an operation.
      start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         start8 = 1'b0;
         chk($sformatf("pre-reset c%0d", i), {busy8, done8, eq8, gt8, lt8}, 5'b10100);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async reset", {busy8, done8, eq8, gt8, lt8}, 5'b00000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("post-reset quiet %0d", i), {busy8, done8, eq8, gt8, lt8}, 5'b00000);
      end
      prev8 = 3'b000;
      run8("after reset lt 7F/80", 8'h7F, 8'h80, 3'b001, 0);

      // WIDTH=1 instance.
      @(negedge clk);
      start1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
      @(negedge clk);
      start1 = 1'b0;
      chk("w1 gt busy", {busy1, done1, eq1, gt1, lt1}, 5'b10000);
      @(negedge clk);
      chk("w1 gt done", {busy1, done1, eq1, gt1, lt1}, 5'b01010);
      @(negedge clk);
      chk("w1 idle", {busy1, done1, eq1, gt1, lt1}, 5'b00010);
      start1 = 1'b1; a1 = 1'b0; b1 = 1'b0;
      @(negedge clk);
      start1 = 1'b0;
      chk("w1 eq busy", {busy1, done1, eq1, gt1, lt1}, 5'b10010);
      @(negedge clk);
      chk("w1 eq done", {busy1, done1, eq1, gt1, lt1}, 5'b01100);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
